// File: rtl/weight_mem_pkg.sv
// Shared types and limits for the weight memory arbiter.
package weight_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    SRC_RD = 1'b0,
    SRC_WR = 1'b1
  } src_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int LAT_W      = 2;
  localparam int N_RD_MAX   = 4;

endpackage

// File: rtl/weight_mem_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request bit at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Scan from the farthest slot back toward ptr so the nearest hit is written last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        idx_o   = IW'((int'(ptr_i) + k) % N);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_mem_arbiter.sv
// Single-port weight memory arbiter: one writer (priority) and N_RD round-robin readers.
// Optional write-starvation guard enabled by defining WMEM_STARVE_GUARD_EN.
module weight_mem_arbiter
  import weight_mem_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DW     = 8,
  parameter int N_RD   = 2,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD-1:0]        rd_req_i,
  input  logic [N_RD*ADDR_W-1:0] rd_addr_i,
  output logic [N_RD-1:0]        rd_valid_o,
  output logic [DW-1:0]          rd_data_o,
  input  logic                   wr_req_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [DW-1:0]          wr_data_i,
  output logic                   wr_ack_o,
  output logic                   mem_en_o,
  output logic                   mem_we_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DW-1:0]          mem_wdata_o,
  input  logic [DW-1:0]          mem_rdata_i,
  output logic                   busy_o
);

  localparam int IW = (N_RD > 1) ? $clog2(N_RD) : 1;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("RD_LAT out of range");
  end
  if (N_RD < 1 || N_RD > N_RD_MAX) begin : g_bad_nrd
    $error("N_RD out of range");
  end

  state_e                       state_q, state_d;
  src_e                         src_q, src_d;
  logic [IW-1:0]                gidx_q, gidx_d;
  logic [IW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [LAT_W-1:0]             lat_q, lat_d;
  logic [N_RD-1:0]              pend_rd_q, pend_rd_d, clr_rd;
  logic [N_RD-1:0][ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic                         pend_wr_q, pend_wr_d, clr_wr;
  logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
  logic [DW-1:0]                wr_data_q, wr_data_d;
  logic [N_RD-1:0]              rd_valid_q, rd_valid_d;
  logic [DW-1:0]                rd_data_q, rd_data_d;
  logic                         wr_ack_q, wr_ack_d;
  logic                         mem_en_q, mem_en_d;
  logic                         mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
  logic [DW-1:0]                mem_wdata_q, mem_wdata_d;
  logic                         busy_q, busy_d;
  logic [IW-1:0]                pick_idx;
  logic                         pick_found;
  logic                         take_rd;
`ifdef WMEM_STARVE_GUARD_EN
  logic [1:0]                   sc_q, sc_d;
`endif

  // A new pulse wins over a same-cycle grant clear and always refreshes the payload.
  for (genvar i = 0; i < N_RD; i++) begin : g_rd_cap
    assign pend_rd_d[i] = rd_req_i[i] | (pend_rd_q[i] & ~clr_rd[i]);
    assign rd_addr_d[i] = rd_req_i[i] ? rd_addr_i[i*ADDR_W +: ADDR_W] : rd_addr_q[i];
  end

  assign pend_wr_d = wr_req_i | (pend_wr_q & ~clr_wr);
  assign wr_addr_d = wr_req_i ? wr_addr_i : wr_addr_q;
  assign wr_data_d = wr_req_i ? wr_data_i : wr_data_q;

  rr_pick #(.N(N_RD), .IW(IW)) u_pick (
    .req_i   (pend_rd_q),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

`ifdef WMEM_STARVE_GUARD_EN
  assign take_rd = pick_found & (~pend_wr_q | (sc_q == 2'd3));
`else
  assign take_rd = pick_found & ~pend_wr_q;
`endif

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    lat_d       = lat_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = '0;
    wr_ack_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    clr_wr      = 1'b0;
    clr_rd      = '0;
`ifdef WMEM_STARVE_GUARD_EN
    sc_d        = sc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pend_wr_q && !take_rd) begin
          src_d       = SRC_WR;
          clr_wr      = 1'b1;
          state_d     = S_ISSUE;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_q;
          mem_wdata_d = wr_data_q;
`ifdef WMEM_STARVE_GUARD_EN
          if (|pend_rd_q && sc_q != 2'd3) sc_d = sc_q + 2'd1;
`endif
        end else if (take_rd) begin
          src_d            = SRC_RD;
          gidx_d           = pick_idx;
          clr_rd[pick_idx] = 1'b1;
          rr_ptr_d         = (pick_idx == IW'(N_RD - 1)) ? '0 : pick_idx + 1'b1;
          state_d          = S_ISSUE;
          mem_en_d         = 1'b1;
          mem_addr_d       = rd_addr_q[pick_idx];
`ifdef WMEM_STARVE_GUARD_EN
          sc_d             = 2'd0;
`endif
        end
      end
      S_ISSUE: begin
        if (src_q == SRC_WR) begin
          state_d  = S_RESP;
          wr_ack_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          lat_d   = LAT_W'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        // Response strobe is registered here so it lands in S_RESP with the data.
        if (lat_q == '0) begin
          rd_data_d          = mem_rdata_i;
          rd_valid_d[gidx_q] = 1'b1;
          state_d            = S_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef WMEM_STARVE_GUARD_EN
    if (pend_rd_q == '0) sc_d = 2'd0;
`endif
  end

  assign busy_d = (state_d != S_IDLE) | (|pend_rd_d) | pend_wr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      src_q       <= SRC_RD;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      lat_q       <= '0;
      pend_rd_q   <= '0;
      rd_addr_q   <= '0;
      pend_wr_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      wr_ack_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef WMEM_STARVE_GUARD_EN
      sc_q        <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      lat_q       <= lat_d;
      pend_rd_q   <= pend_rd_d;
      rd_addr_q   <= rd_addr_d;
      pend_wr_q   <= pend_wr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      wr_ack_q    <= wr_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
`ifdef WMEM_STARVE_GUARD_EN
      sc_q        <= sc_d;
`endif
    end
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign wr_ack_o    = wr_ack_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// Scoreboard bench for weight_mem_arbiter (RD_LAT=1 main instance, RD_LAT=3 latency instance).
module tb_weight_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NR-1:0]    rd_req, rd_valid;
  logic [NR*AW-1:0] rd_addr;
  logic [DW-1:0]    rd_data, wr_data, mem_wdata, mem_rdata;
  logic [AW-1:0]    wr_addr, mem_addr;
  logic             wr_req, wr_ack, mem_en, mem_we, busy;

  logic [NR-1:0]    r3_req, r3_valid;
  logic [NR*AW-1:0] r3_addr;
  logic [DW-1:0]    r3_data, m3_wdata, m3_rdata;
  logic [DW-1:0]    w3_data = '0;
  logic [AW-1:0]    w3_addr = '0, m3_addr;
  logic             w3_req = 1'b0, w3_ack, m3_en, m3_we, busy3;

  weight_mem_arbiter #(.ADDR_W(AW), .DW(DW), .N_RD(NR), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_ack_o(wr_ack), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy));

  weight_mem_arbiter #(.ADDR_W(AW), .DW(DW), .N_RD(NR), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .rd_req_i(r3_req), .rd_addr_i(r3_addr), .rd_valid_o(r3_valid),
    .rd_data_o(r3_data), .wr_req_i(w3_req), .wr_addr_i(w3_addr), .wr_data_i(w3_data),
    .wr_ack_o(w3_ack), .mem_en_o(m3_en), .mem_we_o(m3_we), .mem_addr_o(m3_addr),
    .mem_wdata_o(m3_wdata), .mem_rdata_i(m3_rdata), .busy_o(busy3));

  function automatic logic [7:0] init_val(input int i);
    logic [3:0] n;
    n = i[3:0];
    if (i == 0) return 8'hEE;
    if (i == 5) return 8'h3C;
    return {n, n};
  endfunction

  // Memory models: reload on reset, read data valid RD_LAT cycles after the access.
  logic [7:0] mem1 [16];
  logic [7:0] mem3 [16];
  logic [7:0] rp1;
  logic [7:0] p3 [3];

  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 16; i++) mem1[i] <= init_val(i);
    else if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
    rp1 <= mem1[mem_addr];
  end
  assign mem_rdata = rp1;

  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 16; i++) mem3[i] <= init_val(i);
    else if (m3_en && m3_we) mem3[m3_addr] <= m3_wdata;
    p3[0] <= mem3[m3_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign m3_rdata = p3[2];

  typedef struct {
    bit         wr;
    int         idx;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int men_cnt = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push(input bit wr, input int idx, input logic [7:0] d, input int c);
    exp_t e;
    e.wr = wr; e.idx = idx; e.data = d; e.cyc = c;
    sb.push_back(e);
  endfunction

  exp_t me;
  always @(negedge clk) begin
    if (mem_en) men_cnt++;
    if (rd_valid != '0 || wr_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {29'd0, rd_valid, wr_ack}, 32'd0);
      end else begin
        me = sb.pop_front();
        if (me.wr) begin
          chk("wr_ack_cycle", cyc, me.cyc);
          chk("wr_ack_excl", {29'd0, rd_valid, wr_ack}, 32'd1);
        end else begin
          chk("rd_cycle", cyc, me.cyc);
          chk("rd_valid_onehot", {30'd0, rd_valid}, 32'd1 << me.idx);
          chk("rd_data", {24'd0, rd_data}, {24'd0, me.data});
        end
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_valid"}, {30'd0, rd_valid}, 0);
    chk({tag, "_wr_ack"}, {31'd0, wr_ack}, 0);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 0);
    chk({tag, "_mem_addr"}, {28'd0, mem_addr}, 0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 0);
    chk({tag, "_rd_data"}, {24'd0, rd_data}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t, t2, m0, vcyc, vcnt, m3c;
  logic [7:0] vdata;
  logic [1:0] vbits;

  initial begin
    rd_req = '0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    r3_req = '0; r3_addr = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    chk("rst_r3_valid", {30'd0, r3_valid}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single read, reader 0, addr 5
    t = cyc;
    rd_req = 2'b01; rd_addr = {4'd0, 4'd5};
    push(0, 0, 8'h3C, t + 4);
    @(negedge clk);
    rd_req = '0;
    chk("t1_busy_hi", {31'd0, busy}, 1);
    chk("t1_men_early", {31'd0, mem_en}, 0);
    @(negedge clk);
    chk("t1_men", {31'd0, mem_en}, 1);
    chk("t1_maddr", {28'd0, mem_addr}, 5);
    chk("t1_mwe", {31'd0, mem_we}, 0);
    @(negedge clk);
    chk("t1_men_late", {31'd0, mem_en}, 0);
    wait_to(t + 5);
    chk("t1_busy_lo", {31'd0, busy}, 0);

    // Simultaneous reads from pointer 0
    do_reset();
    t = cyc;
    rd_req = 2'b11; rd_addr = {4'd2, 4'd1};
    push(0, 0, 8'h11, t + 4);
    push(0, 1, 8'h22, t + 8);
    @(negedge clk);
    rd_req = '0;
    wait_to(t + 10);

    // Write priority over read to the same address
    t = cyc; m0 = men_cnt;
    wr_req = 1'b1; wr_addr = 4'd2; wr_data = 8'hA5;
    rd_req = 2'b10; rd_addr = {4'd2, 4'd0};
    push(1, 0, 8'h00, t + 3);
    push(0, 1, 8'hA5, t + 7);
    @(negedge clk);
    wr_req = 1'b0; rd_req = '0;
    wait_to(t + 9);
    chk("t3_men_cnt", men_cnt - m0, 2);

    // Round-robin: pointer advances past reader 0, so reader 1 wins the tie
    t = cyc;
    rd_req = 2'b01; rd_addr = {4'd0, 4'd3};
    push(0, 0, 8'h33, t + 4);
    @(negedge clk);
    rd_req = '0;
    wait_to(t + 6);
    t2 = cyc;
    rd_req = 2'b11; rd_addr = {4'd6, 4'd4};
    push(0, 1, 8'h66, t2 + 4);
    push(0, 0, 8'h44, t2 + 8);
    @(negedge clk);
    rd_req = '0;
    wait_to(t2 + 10);

    // Pending read overwritten while a write is served: one read, newest address
    t = cyc;
    wr_req = 1'b1; wr_addr = 4'd9; wr_data = 8'h5A;
    rd_req = 2'b01; rd_addr = {4'd0, 4'd7};
    push(1, 0, 8'h00, t + 3);
    push(0, 0, 8'h88, t + 7);
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 2'b01; rd_addr = {4'd0, 4'd8};
    @(negedge clk);
    rd_req = '0;
    wait_to(t + 9);
    chk("t5_mem9", {24'd0, mem1[9]}, 32'h5A);

    // Pulse in the grant cycle keeps the bit set: two reads
    t = cyc;
    rd_req = 2'b01; rd_addr = {4'd0, 4'd7};
    push(0, 0, 8'h77, t + 4);
    @(negedge clk);
    rd_req = 2'b01; rd_addr = {4'd0, 4'd10};
    push(0, 0, 8'hAA, t + 8);
    @(negedge clk);
    rd_req = '0;
    wait_to(t + 10);

    // Reset during S_WAIT drops the response and both pending reads
    t = cyc;
    rd_req = 2'b11; rd_addr = {4'd1, 4'd5};
    @(negedge clk);
    rd_req = '0;
    wait_to(t + 3);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    m0 = men_cnt;
    wait_to(t + 16);
    chk("midrst_no_men", men_cnt - m0, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_sb", sb.size(), 0);

    // Continuous writes with one pending read
    t = cyc;
`ifdef WMEM_STARVE_GUARD_EN
    push(1, 0, 8'h00, t + 3);
    push(1, 0, 8'h00, t + 6);
    push(1, 0, 8'h00, t + 9);
    push(0, 0, 8'h3C, t + 13);
    push(1, 0, 8'h00, t + 16);
`else
    push(1, 0, 8'h00, t + 3);
    push(1, 0, 8'h00, t + 6);
    push(1, 0, 8'h00, t + 9);
    push(1, 0, 8'h00, t + 12);
    push(0, 0, 8'h3C, t + 16);
`endif
    for (int k = 0; k < 9; k++) begin
      wr_req = 1'b1; wr_addr = 4'd12; wr_data = 8'hC0 + 8'(k);
      rd_req = (k == 0) ? 2'b01 : 2'b00; rd_addr = {4'd0, 4'd5};
      @(negedge clk);
    end
    wr_req = 1'b0; rd_req = '0;
    wait_to(t + 20);
    chk("t7_mem12", {24'd0, mem1[12]}, 32'hC8);

    // RD_LAT=3 instance, reader 1
    t = cyc;
    r3_req = 2'b10; r3_addr = {4'd6, 4'd0};
    vcyc = 0; vcnt = 0; m3c = 0; vdata = '0; vbits = '0;
    @(negedge clk);
    r3_req = '0;
    while (cyc <= t + 9) begin
      if (r3_valid != '0) begin
        vcyc = cyc; vcnt++; vdata = r3_data; vbits = r3_valid;
      end
      if (m3_en) m3c++;
      @(negedge clk);
    end
    chk("lat3_cycle", vcyc, t + 6);
    chk("lat3_count", vcnt, 1);
    chk("lat3_data", {24'd0, vdata}, 32'h66);
    chk("lat3_onehot", {30'd0, vbits}, 2);
    chk("lat3_men_cnt", m3c, 1);

    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_mem_arbiter.md
Name: weight_mem_arbiter

Overview:
- Owns the single-port weight memory and shares it between N_RD inference readers and one reward-update writer.
- Readers use the layer-engine weight channel: one-cycle `w_req` pulse with address, then wait for a one-cycle valid with data.
- The writer commits reward-adjusted weights.
- One memory transaction is in flight at a time. Writes have priority; readers are served round-robin.

Parameters:
- ADDR_W, 4, weight memory address width
- DW, 8, weight word width (two signed 4-bit weights per word)
- N_RD, 2, number of read requesters (1..4)
- RD_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata (1..3)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_req  in  N_RD  per-reader one-cycle request pulse
- rd_addr  in  N_RD*ADDR_W  per-reader address, reader i at [i*ADDR_W +: ADDR_W], sampled with rd_req[i]
- rd_valid  out  N_RD  one-hot, one-cycle response strobe
- rd_data  out  DW  read data, shared by all readers, meaningful when any rd_valid bit is high
- wr_req  in  1  write request pulse
- wr_addr  in  ADDR_W  write address, sampled with wr_req
- wr_data  in  DW  write data, sampled with wr_req
- wr_ack  out  1  one-cycle write-complete strobe
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high when the FSM is not in S_IDLE or any request is pending

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. rst forces the following, even mid-transaction; any in-flight response is dropped:
  - all outputs 0; state S_IDLE
  - pending bits cleared; round-robin pointer = 0
- Request capture:
  - rd_req[i] sets pend_rd[i] and latches its address.
  - wr_req sets pend_wr and latches address and data.
  - A pulse arriving in the same cycle its pending bit is cleared by a grant wins: the bit stays set and the new address/data replaces the old.
  - A pulse while the bit is already set overwrites the address/data. The request is not duplicated.
- FSM states, all outputs registered:
  - S_IDLE:
    - If pend_wr, grant the write.
    - Else if any pend_rd, grant the first set bit at or after rr_ptr (wrapping); then rr_ptr = grant+1 mod N_RD.
    - Granting clears the pending bit and goes to S_ISSUE. With no request, stay in S_IDLE.
  - S_ISSUE: mem_en=1, mem_addr and mem_we (and mem_wdata for a write) driven for exactly one cycle. A write goes to S_RESP; a read goes to S_WAIT.
  - S_WAIT: a counter runs RD_LAT cycles. On the last cycle, mem_rdata is captured into rd_data. Then go to S_RESP.
  - S_RESP: pulse rd_valid[grant] or wr_ack for one cycle, then go to S_IDLE.
- Latency (grant cycle G = IDLE cycle where pending is seen):
  - A pulse in cycle t gives G = t+1.
  - Read: mem_en in G+1; rd_valid in G+2+RD_LAT (t+4 when RD_LAT=1).
  - Write: mem_en in G+1; wr_ack in G+2.
  - The next grant can occur in the cycle after S_RESP.
- rd_data holds its value until the next read capture. mem_* outputs return to 0 outside S_ISSUE.
- Read and write to the same address both pending: the write is granted first, so the read returns the new data.
- Protocol rule: a reader must not pulse again before its rd_valid. If it does, one extra transaction is served.

Optional Feature:
- Macro WMEM_STARVE_GUARD_EN.
- Defined:
  - A 2-bit counter counts consecutive write grants made while any pend_rd is set.
  - When the counter reaches 3 and a read is pending, the next S_IDLE grant goes to the round-robin reader; the counter then clears.
  - The counter also clears on any read grant, or when no read is pending.
- Undefined: writes have strict priority and the counter logic is absent.

Decomposition:
- Package weight_mem_pkg holds:
  - the state enum (S_IDLE, S_ISSUE, S_WAIT, S_RESP)
  - the reader/writer grant-source type
  - the RD_LAT limit constants
- Sub-module rr_pick is natural: a combinational round-robin first-set-bit finder over N_RD bits with a pointer input, returning grant index and found flag.

Test Plan:
- Single read: memory[5]=0x3C, rd_req[0] pulse addr 5 in cycle 0 (RD_LAT=1) -> mem_en with addr 5 in cycle 2; rd_valid=2'b01 and rd_data=0x3C in cycle 4; busy low in cycle 5.
- Simultaneous reads: rd_req=2'b11 (addr 1 and 2) in cycle 0, rr_ptr=0 -> reader 0 served first (rd_valid cycle 4), then reader 1 (rd_valid cycle 8).
- Write priority: wr_req (addr 2, data 0xA5) and rd_req[1] (addr 2) in the same cycle -> wr_ack first, then rd_valid[1] with rd_data=0xA5.
- Latency sweep: RD_LAT=3, read at cycle 0 -> rd_valid in cycle 6; exactly one mem_en cycle per transaction.
- Reset mid-read: rst in S_WAIT -> next cycle all outputs 0, no rd_valid ever issued, pending cleared.
- With WMEM_STARVE_GUARD_EN: wr_req every cycle plus rd_req[0] held pending -> reader 0 granted after the third write grant. Without the macro -> the read waits until writes stop.
